// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the fetch stage and its branch target buffer
package if_pkg;

  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  localparam logic [1:0]  CTR_WEAK_TAKEN   = 2'b10;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - fully associative BTB with 2-bit counters and FIFO replacement
module btb_table
  import if_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_tag,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [29:0] upd_tag,
  input  logic [29:0] upd_target,
  input  logic        upd_taken
);

  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  btb_entry_t             entries [ENTRIES];
  logic [PTR_W-1:0]       victim;

  logic                   lk_hit;
  logic [PTR_W-1:0]       lk_idx;
  logic                   up_hit;
  logic [PTR_W-1:0]       up_idx;

  // Allocation only happens on a miss, so at most one entry can match a tag.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    up_hit = 1'b0;
    up_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries[i].valid && entries[i].tag == lookup_tag) begin
        lk_hit = 1'b1;
        lk_idx = PTR_W'(i);
      end
      if (entries[i].valid && entries[i].tag == upd_tag) begin
        up_hit = 1'b1;
        up_idx = PTR_W'(i);
      end
    end
  end

  assign pred_taken  = lk_hit & entries[lk_idx].ctr[1];
  assign pred_target = {entries[lk_idx].target, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
      victim <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        entries[up_idx].ctr <= ctr_next(entries[up_idx].ctr, upd_taken);
        if (upd_taken) begin
          entries[up_idx].target <= upd_target;
        end
      end else if (upd_taken) begin
        entries[victim] <= '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CTR_WEAK_TAKEN};
        victim          <= victim + 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_fetch_btb.sv
// rtl/if_fetch_btb.sv - IF stage: fetch PC register, next-PC select and BTB prediction
module if_fetch_btb
  import if_pkg::*;
#(
  parameter int          BTB_ENTRIES = 8,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic [31:0] Upd_Target,
  input  logic        Upd_Taken,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IMem_Addr,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_four,
  output logic [31:0] Instr,
  output logic        PredictJump
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pred_target;
  logic        pred_taken;
  logic        unused_low_bits;

  btb_table #(
    .ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk        (CLK),
    .rst        (CLR),
    .lookup_tag (pc_q[31:2]),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd_valid  (Upd_Valid),
    .upd_tag    (Upd_PC[31:2]),
    .upd_target (Upd_Target[31:2]),
    .upd_taken  (Upd_Taken)
  );

  assign unused_low_bits = ^{Redirect_PC[1:0], Upd_PC[1:0], Upd_Target[1:0]};

  // An EX correction outranks a hazard stall; the stall outranks the prediction.
  always_comb begin
    pc_next = pc_q + 32'd4;
    if (Redirect)        pc_next = {Redirect_PC[31:2], 2'b00};
    else if (Stall)      pc_next = pc_q;
    else if (pred_taken) pc_next = pred_target;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) pc_q <= {RESET_PC[31:2], 2'b00};
    else     pc_q <= pc_next;
  end

  assign PC           = pc_q;
  assign IMem_Addr    = pc_q;
  assign PC_plus_four = pc_q + 32'd4;
  assign Instr        = IMem_Data;
  assign PredictJump  = pred_taken;

endmodule

// File: tb/tb_if_fetch_btb.sv
// tb/tb_if_fetch_btb.sv - scoreboard bench for if_fetch_btb
module tb_if_fetch_btb;

  logic        CLK;
  logic        CLR;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Upd_Valid;
  logic [31:0] Upd_PC;
  logic [31:0] Upd_Target;
  logic        Upd_Taken;
  logic [31:0] IMem_Data;
  logic [31:0] IMem_Addr;
  logic [31:0] PC;
  logic [31:0] PC_plus_four;
  logic [31:0] Instr;
  logic        PredictJump;

  localparam logic [31:0] IMEM_KEY = 32'h5A5A_C3C3;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pj;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  if_fetch_btb #(
    .BTB_ENTRIES(8),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .Upd_Valid   (Upd_Valid),
    .Upd_PC      (Upd_PC),
    .Upd_Target  (Upd_Target),
    .Upd_Taken   (Upd_Taken),
    .IMem_Data   (IMem_Data),
    .IMem_Addr   (IMem_Addr),
    .PC          (PC),
    .PC_plus_four(PC_plus_four),
    .Instr       (Instr),
    .PredictJump (PredictJump)
  );

  assign IMem_Data = IMem_Addr ^ IMEM_KEY;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    else n_pass++;
  endtask

  // Monitor: outputs are stable between edges, so sample well after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "PC", PC, e.pc);
        check(e.name, "PC_plus_four", PC_plus_four, e.pc + 32'd4);
        check(e.name, "PredictJump", {31'd0, PredictJump}, {31'd0, e.pj});
        check(e.name, "IMem_Addr", IMem_Addr, e.pc);
        check(e.name, "Instr", Instr, e.pc ^ IMEM_KEY);
      end
    end
  end

  // One fetch cycle: drive this cycle's inputs and record what the outputs must be now.
  task automatic tick(input string name, input logic [31:0] exp_pc, input logic exp_pj,
                      input logic stall, input logic redir, input logic [31:0] rpc,
                      input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                      input logic utk);
    exp_t e;
    @(negedge CLK);
    Stall       = stall;
    Redirect    = redir;
    Redirect_PC = rpc;
    Upd_Valid   = uv;
    Upd_PC      = upc;
    Upd_Target  = utgt;
    Upd_Taken   = utk;
    e.name = name;
    e.pc   = exp_pc;
    e.pj   = exp_pj;
    sb.push_back(e);
  endtask

  task automatic run(input string name, input logic [31:0] exp_pc, input logic exp_pj);
    tick(name, exp_pc, exp_pj, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input string name, input logic [31:0] exp_pc, input logic exp_pj, input logic [31:0] rpc);
    tick(name, exp_pc, exp_pj, 0, 1, rpc, 0, 0, 0, 0);
  endtask

  task automatic train(input string name, input logic [31:0] exp_pc, input logic exp_pj,
                       input logic [31:0] upc, input logic [31:0] utgt, input logic utk);
    tick(name, exp_pc, exp_pj, 0, 0, 0, 1, upc, utgt, utk);
  endtask

  initial begin
    CLR = 1'b1;
    Stall = 0; Redirect = 0; Redirect_PC = 0;
    Upd_Valid = 0; Upd_PC = 0; Upd_Target = 0; Upd_Taken = 0;

    run("reset", 32'h0, 0);
    @(posedge CLK);
    #1 CLR = 1'b0;

    run("seq0", 32'h0, 0);
    run("seq4", 32'h4, 0);
    run("seq8", 32'h8, 0);
    run("seqC", 32'hC, 0);

    // Lookup misses on the same cycle the entry is allocated.
    train("miss_train", 32'h10, 0, 32'h10, 32'h40, 1);
    jump("fallthru14", 32'h14, 0, 32'h0);
    run("re0", 32'h0, 0);
    run("re4", 32'h4, 0);
    run("re8", 32'h8, 0);
    run("reC", 32'hC, 0);
    run("hit10", 32'h10, 1);
    train("tgt40_nt", 32'h40, 0, 32'h10, 32'h0, 0);
    tick("nt2_redir", 32'h44, 0, 0, 1, 32'h10, 1, 32'h10, 32'h0, 0);
    run("ctr0_10", 32'h10, 0);
    tick("sat_lo", 32'h14, 0, 0, 1, 32'h10, 1, 32'h10, 32'h0, 0);
    run("sat_lo_10", 32'h10, 0);
    train("inc1", 32'h14, 0, 32'h10, 32'h40, 1);
    train("inc2", 32'h18, 0, 32'h10, 32'h40, 1);
    train("inc3", 32'h1C, 0, 32'h10, 32'h40, 1);
    train("inc_sat", 32'h20, 0, 32'h10, 32'h40, 1);
    tick("dec_from3", 32'h24, 0, 0, 1, 32'h10, 1, 32'h10, 32'h0, 0);
    run("sat_hi_10", 32'h10, 1);
    jump("sat_hi_40", 32'h40, 0, 32'h8);

    // Stall holds PC while training still lands; redirect beats the stall.
    tick("stall1", 32'h8, 0, 1, 0, 0, 1, 32'h100, 32'h200, 1);
    tick("stall2", 32'h8, 0, 1, 0, 0, 0, 0, 0, 0);
    tick("stall3", 32'h8, 0, 1, 1, 32'h103, 0, 0, 0, 0);
    run("redir100", 32'h100, 1);
    run("tgt200", 32'h200, 0);

    #2 CLR = 1'b1;
    @(posedge CLK);
    #1 CLR = 1'b0;
    run("async_rst", 32'h0, 0);
    run("ar4", 32'h4, 0);
    run("ar8", 32'h8, 0);
    run("arC", 32'hC, 0);
    jump("ar10_miss", 32'h10, 0, 32'h100);
    run("ar100_miss", 32'h100, 0);

    for (int i = 0; i < 9; i++) begin
      tick($sformatf("alloc%0d", i), 32'h104 + 32'(4 * i), 0, 0, (i == 8), 32'h0,
           1, 32'(4 * i), 32'h1000 + 32'(4 * i), 1);
    end
    run("evicted0", 32'h0, 0);
    for (int a = 4; a <= 32'h20; a += 4) begin
      run($sformatf("hit%0h", a), 32'(a), 1);
      if (a < 32'h20) jump($sformatf("tgt%0h", a), 32'h1000 + 32'(a), 0, 32'(a + 4));
    end
    tick("alloc24", 32'h1020, 0, 0, 1, 32'h4, 1, 32'h24, 32'h1024, 1);
    run("evicted4", 32'h4, 0);
    run("kept8", 32'h8, 1);
    jump("tgt1008", 32'h1008, 0, 32'h24);
    run("hit24", 32'h24, 1);
    jump("tgt1024", 32'h1024, 0, 32'hFFFF_FFFC);
    run("wrap_top", 32'hFFFF_FFFC, 0);
    run("wrap_zero", 32'h0, 0);

    @(negedge CLK);
    #4;
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
